// File: rtl/async_ctl_pkg.sv
// Shared types and defaults for the clocked supervisor of the self-timed controller ring.
package async_ctl_pkg;

  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StInject = 3'd1,
    StRtz    = 3'd2,
    StRun    = 3'd3,
    StStall  = 3'd4
  } async_seq_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous level, plus a rising-edge detector on its output.
module sync_edge
  import async_ctl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], raw};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign level = chain_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/async_token_sequencer.sv
// Injects the initial token into the fetch controller with a 4-phase handshake, counts retired
// tokens and watches for a stalled ring.
module async_token_sequencer
  import async_ctl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned WDOG_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              restart_i,
  input  logic              clr_cnt_i,
  input  logic [WDOG_W-1:0] wdog_limit_i,
  input  logic              ife_ack_i,
  input  logic              ring_done_i,
  output logic              req_rst_o,
  output logic              retire_pulse_o,
  output logic [CNT_W-1:0]  retire_cnt_o,
  output logic              stall_o,
  output logic [2:0]        state_o
);

  logic ack_s, ack_rise;
  logic done_s, done_rise;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_ack (
    .clk  (clk_i),
    .rst  (rst_i),
    .raw  (ife_ack_i),
    .level(ack_s),
    .rise (ack_rise)
  );

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_done (
    .clk  (clk_i),
    .rst  (rst_i),
    .raw  (ring_done_i),
    .level(done_s),
    .rise (done_rise)
  );

  // The handshake only needs the ack level and the retire path only needs the done edge.
  logic unused_sync;
  assign unused_sync = ack_rise ^ done_s;

  async_seq_state_e  state_q, state_d;
  logic              req_q, stall_q, stall_d, pulse_q, pulse_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic              timeout;

  assign wdog_inc = (&wdog_q) ? wdog_q : wdog_q + WDOG_W'(1);
  assign timeout  = (wdog_limit_i != '0) && (wdog_inc == wdog_limit_i);

  always_comb begin
    state_d = state_q;
    stall_d = stall_q;
    wdog_d  = '0;
    unique case (state_q)
      StIdle: begin
        stall_d = 1'b0;
        if (en_i && !ack_s) state_d = StInject;
      end
      StInject: begin
        // A timeout only flags; the request is held so the 4-phase protocol stays intact.
        wdog_d = wdog_inc;
        if (ack_s) begin
          state_d = StRtz;
          stall_d = 1'b0;
        end else if (timeout) begin
          stall_d = 1'b1;
        end
      end
      StRtz: begin
        stall_d = 1'b0;
        if (!ack_s) state_d = en_i ? StRun : StIdle;
      end
      StRun: begin
        if (!en_i) begin
          state_d = StIdle;
        end else if (done_rise) begin
          wdog_d = '0;
        end else if (timeout) begin
          state_d = StStall;
          stall_d = 1'b1;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      StStall: begin
        if (restart_i || !en_i) begin
          state_d = StIdle;
          stall_d = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        stall_d = 1'b0;
      end
    endcase
  end

  // Retirements count in RUN and STALL only; a coincident clear keeps the new token.
  always_comb begin
    pulse_d = done_rise && ((state_q == StRun) || (state_q == StStall));
    cnt_d   = cnt_q;
    if (pulse_d) begin
      cnt_d = clr_cnt_i ? CNT_W'(1) : cnt_q + CNT_W'(1);
    end else if (clr_cnt_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      stall_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == StInject);
      stall_q <= stall_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
    end
  end

  assign req_rst_o      = req_q;
  assign retire_pulse_o = pulse_q;
  assign retire_cnt_o   = cnt_q;
  assign stall_o        = stall_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_async_token_sequencer.sv
// Bench for async_token_sequencer: models the fetch controller and ring, checks timing by arithmetic.
module tb_async_token_sequencer;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned WDOG_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INJECT = 3'd1;
  localparam logic [2:0] ST_RTZ    = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_STALL  = 3'd4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic              restart = 1'b0;
  logic              clr_cnt = 1'b0;
  logic [WDOG_W-1:0] wdog_limit = '0;
  logic              ife_ack = 1'b0;
  logic              ring_done = 1'b0;
  logic              req_rst, retire_pulse, stall;
  logic [CNT_W-1:0]  retire_cnt;
  logic [2:0]        state;

  async_token_sequencer #(
    .SYNC_STAGES(SYNC),
    .CNT_W      (CNT_W),
    .WDOG_W     (WDOG_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .en_i          (en),
    .restart_i     (restart),
    .clr_cnt_i     (clr_cnt),
    .wdog_limit_i  (wdog_limit),
    .ife_ack_i     (ife_ack),
    .ring_done_i   (ring_done),
    .req_rst_o     (req_rst),
    .retire_pulse_o(retire_pulse),
    .retire_cnt_o  (retire_cnt),
    .stall_o       (stall),
    .state_o       (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // Fetch-controller model: ack follows req after programmable delays.
  int ack_rise_dly = 3;
  int ack_fall_dly = 3;
  int rise_cnt = -1;
  int fall_cnt = -1;
  bit req_prev = 1'b0;

  int               last_pulse_cyc = -1;
  logic [CNT_W-1:0] cnt_at_pulse = '0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (req_rst && !req_prev) rise_cnt = ack_rise_dly;
    if (!req_rst && req_prev) begin
      if (ife_ack) fall_cnt = ack_fall_dly;
      else rise_cnt = -1;
    end
    req_prev = req_rst;
    if (rise_cnt == 0) begin
      ife_ack = 1'b1;
      rise_cnt = -1;
    end else if (rise_cnt > 0) rise_cnt--;
    if (fall_cnt == 0) begin
      ife_ack = 1'b0;
      fall_cnt = -1;
    end else if (fall_cnt > 0) fall_cnt--;
    if (retire_pulse === 1'b1) begin
      last_pulse_cyc = cyc;
      cnt_at_pulse = retire_cnt;
    end
  endtask

  task automatic run_to(input logic [2:0] target, input int budget, output bit ok);
    int i = 0;
    while (state !== target && i < budget) begin
      step();
      i++;
    end
    ok = (state === target);
  endtask

  task automatic send_token(input int h, input int l, input bit clr_hit, output int rise);
    rise = cyc;
    ring_done = 1'b1;
    for (int k = 1; k <= h + l; k++) begin
      step();
      if (k == h) ring_done = 1'b0;
      clr_cnt = (clr_hit && k == SYNC) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    step();
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d, expected %0d", state, ST_IDLE); end
    n_checks++; if (req_rst !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b, expected 0", req_rst); end
    n_checks++; if (retire_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse: got %b, expected 0", retire_pulse); end
    n_checks++; if (retire_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d, expected 0", retire_cnt); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, expected 0", stall); end
    rst = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_handshake();
    logic [2:0] trace[$];
    logic [2:0] exp_seq[4];
    int en_cyc, inj, rtz, run, req_hi;
    exp_seq = '{ST_IDLE, ST_INJECT, ST_RTZ, ST_RUN};
    inj = -1; rtz = -1; run = -1; req_hi = 0;
    ack_rise_dly = 10;
    ack_fall_dly = 5;
    en = 1'b1;
    en_cyc = cyc;
    trace.push_back(state);
    for (int i = 0; i < 100 && state !== ST_RUN; i++) begin
      step();
      if (state !== trace[$]) trace.push_back(state);
      if (req_rst === 1'b1) req_hi++;
      if (state === ST_INJECT && inj < 0) inj = cyc;
      if (state === ST_RTZ && rtz < 0) rtz = cyc;
      if (state === ST_RUN && run < 0) run = cyc;
    end
    n_checks++; if (trace.size() != 4) begin n_fail++; $display("FAIL hs_trace_len: got %0d, expected 4", trace.size()); end
    for (int k = 0; k < 4 && k < trace.size(); k++) begin
      n_checks++; if (trace[k] !== exp_seq[k]) begin n_fail++; $display("FAIL hs_trace[%0d]: got %0d, expected %0d", k, trace[k], exp_seq[k]); end
    end
    n_checks++; if (inj != en_cyc + 1) begin n_fail++; $display("FAIL hs_inject_cycle: got %0d, expected %0d", inj, en_cyc + 1); end
    n_checks++; if (req_hi != 10 + SYNC + 1) begin n_fail++; $display("FAIL hs_req_width: got %0d, expected %0d", req_hi, 10 + SYNC + 1); end
    n_checks++; if (run - rtz != 5 + SYNC + 1) begin n_fail++; $display("FAIL hs_rtz_width: got %0d, expected %0d", run - rtz, 5 + SYNC + 1); end
  endtask

  task automatic test_retire();
    bit exp_pulse[int];
    logic [CNT_W-1:0] model_cnt = '0;
    int pulses = 0;
    for (int i = 0; i < 10; i++) begin
      int h = (i < 5) ? 6 : int'($urandom_range(1, 8));
      int l = int'($urandom_range(2, 8));
      ring_done = 1'b1;
      exp_pulse[cyc + SYNC + 1] = 1'b1;
      for (int k = 0; k < h + l; k++) begin
        bit e;
        step();
        if (k == h - 1) ring_done = 1'b0;
        e = exp_pulse.exists(cyc) ? 1'b1 : 1'b0;
        if (e) model_cnt = model_cnt + CNT_W'(1);
        n_checks++; if (retire_pulse !== e) begin n_fail++; $display("FAIL retire_pulse@%0d: got %b, expected %b", cyc, retire_pulse, e); end
        n_checks++; if (retire_cnt !== model_cnt) begin n_fail++; $display("FAIL retire_cnt@%0d: got %0d, expected %0d", cyc, retire_cnt, model_cnt); end
        if (retire_pulse === 1'b1) pulses++;
      end
      if (i == 4) begin
        n_checks++; if (retire_cnt !== CNT_W'(5)) begin n_fail++; $display("FAIL retire_cnt_five: got %0d, expected 5", retire_cnt); end
      end
    end
    n_checks++; if (pulses != 10) begin n_fail++; $display("FAIL retire_pulse_total: got %0d, expected 10", pulses); end
  endtask

  task automatic test_idle_ignore();
    int stray = 0;
    en = 1'b0;
    step();
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL idle_on_disable: got %0d, expected %0d", state, ST_IDLE); end
    ring_done = 1'b1;
    repeat (4) begin step(); if (retire_pulse !== 1'b0) stray++; end
    ring_done = 1'b0;
    repeat (4) begin step(); if (retire_pulse !== 1'b0) stray++; end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL idle_stray_pulses: got %0d, expected 0", stray); end
    n_checks++; if (retire_cnt !== CNT_W'(10)) begin n_fail++; $display("FAIL idle_cnt_held: got %0d, expected 10", retire_cnt); end
  endtask

  task automatic test_wdog_run();
    for (int it = 0; it < 3; it++) begin
      bit ok;
      int lim = (it == 0) ? 20 : int'($urandom_range(10, 30));
      int t_run, stall_cyc;
      wdog_limit = WDOG_W'(lim);
      ack_rise_dly = int'($urandom_range(1, 4));
      ack_fall_dly = int'($urandom_range(1, 4));
      en = 1'b1;
      run_to(ST_RUN, 60, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wdog_reach_run: got state %0d, expected %0d", state, ST_RUN); end
      t_run = cyc;
      stall_cyc = -1;
      for (int k = 0; k < lim + 10 && stall_cyc < 0; k++) begin
        step();
        if (stall === 1'b1) stall_cyc = cyc;
      end
      n_checks++; if (stall_cyc != t_run + lim) begin n_fail++; $display("FAIL wdog_run_fire(lim=%0d): got cycle %0d, expected %0d", lim, stall_cyc, t_run + lim); end
      n_checks++; if (state !== ST_STALL) begin n_fail++; $display("FAIL wdog_run_state: got %0d, expected %0d", state, ST_STALL); end
      restart = 1'b1;
      step();
      restart = 1'b0;
      n_checks++; if (state !== ST_IDLE || stall !== 1'b0) begin n_fail++; $display("FAIL restart_idle: got state %0d stall %b, expected %0d stall 0", state, stall, ST_IDLE); end
      step();
      n_checks++; if (state !== ST_INJECT || req_rst !== 1'b1) begin n_fail++; $display("FAIL restart_inject: got state %0d req %b, expected %0d req 1", state, req_rst, ST_INJECT); end
      en = 1'b0;
      run_to(ST_IDLE, 60, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wdog_back_idle: got state %0d, expected %0d", state, ST_IDLE); end
    end
    wdog_limit = '0;
  endtask

  task automatic test_wdog_inject();
    bit ok;
    int t0, k, stall_cyc;
    wdog_limit = WDOG_W'(8);
    ack_rise_dly = 20;
    ack_fall_dly = 2;
    en = 1'b1;
    step();
    t0 = cyc;
    n_checks++; if (state !== ST_INJECT) begin n_fail++; $display("FAIL winj_enter: got %0d, expected %0d", state, ST_INJECT); end
    k = 0;
    stall_cyc = -1;
    while (state === ST_INJECT && k < 60) begin
      if (stall === 1'b1 && stall_cyc < 0) begin
        stall_cyc = cyc;
        n_checks++; if (req_rst !== 1'b1) begin n_fail++; $display("FAIL winj_req_held: got %b, expected 1", req_rst); end
      end
      step();
      k++;
    end
    n_checks++; if (stall_cyc != t0 + 8) begin n_fail++; $display("FAIL winj_fire: got cycle %0d, expected %0d", stall_cyc, t0 + 8); end
    n_checks++; if (state !== ST_RTZ) begin n_fail++; $display("FAIL winj_rtz: got %0d, expected %0d", state, ST_RTZ); end
    n_checks++; if (cyc - t0 != 20 + SYNC + 1) begin n_fail++; $display("FAIL winj_len: got %0d, expected %0d", cyc - t0, 20 + SYNC + 1); end
    wdog_limit = '0;
    run_to(ST_RUN, 40, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL winj_reach_run: got state %0d, expected %0d", state, ST_RUN); end
  endtask

  task automatic test_clr_wrap();
    int rise;
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    n_checks++; if (retire_cnt !== '0) begin n_fail++; $display("FAIL clr_alone: got %0d, expected 0", retire_cnt); end
    repeat (7) send_token(3, 3, 1'b0, rise);
    n_checks++; if (retire_cnt !== CNT_W'(7)) begin n_fail++; $display("FAIL cnt_seven: got %0d, expected 7", retire_cnt); end
    send_token(3, 3, 1'b1, rise);
    n_checks++; if (last_pulse_cyc != rise + SYNC + 1) begin n_fail++; $display("FAIL clr_hit_pulse_cycle: got %0d, expected %0d", last_pulse_cyc, rise + SYNC + 1); end
    n_checks++; if (cnt_at_pulse !== CNT_W'(1)) begin n_fail++; $display("FAIL clr_hit_cnt: got %0d, expected 1", cnt_at_pulse); end
    repeat ((1 << CNT_W) - 2) send_token(2, 2, 1'b0, rise);
    n_checks++; if (retire_cnt !== {CNT_W{1'b1}}) begin n_fail++; $display("FAIL cnt_max: got %0d, expected %0d", retire_cnt, (1 << CNT_W) - 1); end
    send_token(2, 2, 1'b0, rise);
    n_checks++; if (cnt_at_pulse !== '0 || last_pulse_cyc != rise + SYNC + 1) begin n_fail++; $display("FAIL cnt_wrap: got %0d at cycle %0d, expected 0 at cycle %0d", cnt_at_pulse, last_pulse_cyc, rise + SYNC + 1); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int rise;
    send_token(2, 2, 1'b0, rise);
    en = 1'b0;
    run_to(ST_IDLE, 20, ok);
    ack_rise_dly = 50;
    en = 1'b1;
    run_to(ST_INJECT, 5, ok);
    repeat (3) step();
    n_checks++; if (state !== ST_INJECT || req_rst !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got state %0d req %b, expected %0d req 1", state, req_rst, ST_INJECT); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    en = 1'b0;
    n_checks++; if (req_rst !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b, expected 0", req_rst); end
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL mid_state: got %0d, expected %0d", state, ST_IDLE); end
    n_checks++; if (retire_cnt !== '0 || stall !== 1'b0) begin n_fail++; $display("FAIL mid_counters: got cnt %0d stall %b, expected 0 and 0", retire_cnt, stall); end
    repeat (3) step();
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL mid_stay_idle: got %0d, expected %0d", state, ST_IDLE); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish, expected finish before time limit");
    $fatal(1, "simulation time limit");
  end

  initial begin
    test_reset();
    test_handshake();
    test_retire();
    test_idle_ignore();
    test_wdog_run();
    test_wdog_inject();
    test_clr_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/async_token_sequencer.md
Name: async_token_sequencer

Overview:
- Clocked supervisor for the self-timed controller network.
- Injects the initial token into the instruction-fetch controller using a 4-phase handshake on req_rst, after reset or on restart.
- Counts tokens retiring at the register-file-write stage, which is the network's completion output, and runs a watchdog that flags a stalled ring.
- Sits directly upstream of the controller network and consumes its completion signal; it is the only clocked logic on the handshake path.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each synchroniser on the asynchronous inputs (legal range 2..4).
- CNT_W, 32, width of the retired-token counter.
- WDOG_W, 16, width of the watchdog counter and of the limit input.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active high.
- en_i  in  1  run enable; level-sensitive.
- restart_i  in  1  one-cycle pulse that leaves STALL and re-injects a token.
- clr_cnt_i  in  1  synchronous clear of retire_cnt_o.
- wdog_limit_i  in  WDOG_W  stall threshold in cycles; 0 disables the watchdog.
- ife_ack_i  in  1  asynchronous; the fetch controller's input acknowledge.
- ring_done_i  in  1  asynchronous; the completion request from register-file write.
- req_rst_o  out  1  token-injection request into the fetch controller.
- retire_pulse_o  out  1  one-cycle pulse per retired token.
- retire_cnt_o  out  CNT_W  count of retired tokens.
- stall_o  out  1  watchdog fired.
- state_o  out  3  current FSM state encoding.

Behaviour:
- Reset (rst_i=1 at a rising clk_i edge):
  - State goes to IDLE; all synchroniser flops clear.
  - req_rst_o=0, retire_pulse_o=0, retire_cnt_o=0, stall_o=0, state_o=IDLE, watchdog=0.
  - Reset overrides every other input, including in the middle of a handshake.
- Synchronisers: ife_ack_i and ring_done_i each pass through a SYNC_STAGES flop chain; the outputs are ack_s and done_s. Only these synchronised versions are used internally.
- All outputs are registered.
- FSM states and encodings: IDLE=0, INJECT=1, RTZ=2, RUN=3, STALL=4.
- IDLE:
  - req_rst_o=0.
  - If en_i=1 and ack_s=0, go to INJECT.
  - If en_i=1 and ack_s=1, remain in IDLE until ack_s returns to 0.
- INJECT:
  - req_rst_o=1.
  - On ack_s=1, go to RTZ.
  - The watchdog runs. On timeout, stall_o=1, but req_rst_o stays 1 and the state stays INJECT, so the 4-phase protocol is never violated.
- RTZ:
  - req_rst_o=0.
  - On ack_s=0, go to RUN, or to IDLE if en_i=0.
- RUN:
  - req_rst_o=0.
  - Rising-edge detect on done_s produces retire_pulse_o=1 for exactly one cycle.
  - On that pulse, retire_cnt_o increments and the watchdog clears.
  - If en_i=0, go to IDLE.
  - If the watchdog reaches wdog_limit_i (nonzero), go to STALL.
- STALL:
  - stall_o=1; retire counting continues.
  - restart_i=1 clears stall_o and goes to IDLE, which re-injects on the next cycle if en_i=1.
  - en_i=0 also goes to IDLE.
- en_i dropping in INJECT is ignored until RTZ completes; the handshake always finishes.
- Watchdog:
  - Counts cycles in INJECT and in RUN; it is held at 0 in every other state.
  - Saturates at all-ones.
  - Compares against wdog_limit_i as "count == limit".
- Retire counter:
  - Wraps modulo 2^CNT_W.
  - If clr_cnt_i and a retire pulse occur in the same cycle, the counter loads 1.
- Latency:
  - A ring_done_i rising edge produces retire_pulse_o SYNC_STAGES+1 cycles later.
  - retire_cnt_o updates on the same edge that raises retire_pulse_o.
- A done_s edge arriving outside RUN/STALL is not counted.

Decomposition:
- Shared package async_ctl_pkg:
  - state enum async_seq_state_e (encodings above);
  - SYNC_STAGES_DEFAULT constant.
- Sub-module sync_edge:
  - a parameterised SYNC_STAGES synchroniser plus rising-edge detector;
  - one instance per asynchronous input.

Test Plan:
- Reset, then en_i=1, with ife_ack_i rising 10 cycles after req_rst_o and falling 5 cycles after req_rst_o drops -> state sequence IDLE, INJECT, RTZ, RUN; req_rst_o high from cycle 1 until ack_s is seen.
- In RUN, toggle ring_done_i 5 times, each high for 6 cycles -> 5 retire pulses, each 3 cycles after its rising edge (SYNC_STAGES=2); retire_cnt_o=5.
- wdog_limit_i=20 with no ring_done_i activity in RUN -> stall_o=1 and state=STALL 20 cycles after entering RUN; restart_i -> IDLE, then INJECT on the next cycle.
- wdog_limit_i=8 with ife_ack_i held low in INJECT -> stall_o=1, req_rst_o stays 1; ack then arrives -> RTZ.
- clr_cnt_i coincident with a retire pulse at count 7 -> retire_cnt_o=1; counter preloaded to 2^CNT_W-1 plus one retire -> wraps to 0.
- rst_i asserted in INJECT with req_rst_o=1 -> next cycle req_rst_o=0, state IDLE, counters 0.
